unidade_controle: RTL

//  Multi-cycle main control FSM for the 16-bit datapath; sits directly upstream of ulaControl.

---
 rtl/unidade_controle_pkg.sv | 54 +++++
 rtl/unidade_controle.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the multi-cycle main control unit:
// opcodes, ALUOp codes (also decoded by ulaControl), mux select codes and state encoding.
package unidade_controle_pkg;

    // Opcode field instr[15:12]
    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0010;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // ALU operation class handed to ulaControl
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } aluop_t;

    // Second ALU operand select
    typedef enum logic [1:0] {
        SRCB_REGB  = 2'b00,
        SRCB_ONE   = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_BROFF = 2'b11
    } alusrcb_t;

    // Next-PC source select
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

endpackage

// File: rtl/unidade_controle.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and ALUOp, stalls on mem_ready, counts retired instructions.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_illegal_op;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_set_illegal;
    logic             w_retire;

    // State register, sticky illegal flag and retired-instruction counter
    // NOTE: async active-low reset in the sensitivity list; all sequential state uses <= so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_INIT;
            r_illegal_op  <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal) r_illegal_op <= 1'b1;
            if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    // Next-state and output decode (Moore, except FETCH PC/IR load follows mem_ready)
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_next_state  = r_state;
        w_set_illegal = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REGB;
        ALUOp         = ALUOP_ADD;
        PCSource      = PCSRC_ALU;
        halted        = 1'b0;

        unique case (r_state)
            S_INIT: w_next_state = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_ONE;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
                if (mem_ready) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BROFF;
                case (opcode)
                    OP_R:          w_next_state = S_EXEC_R;
                    OP_ADDI:       w_next_state = S_EXEC_I;
                    OP_LW, OP_SW:  w_next_state = S_MEM_ADDR;
                    OP_BEQ:        w_next_state = S_BRANCH;
                    OP_J:          w_next_state = S_JUMP;
                    OP_HALT:       w_next_state = S_HALT;
                    default: begin
                        w_next_state  = S_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA      = 1'b1;
                ALUOp        = ALUOP_RTYPE;
                w_next_state = S_WB_R;
            end
            S_WB_R: begin
                RegDst       = 1'b1;
                RegWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                ALUOp        = ALUOP_ITYPE;
                w_next_state = S_WB_I;
            end
            S_WB_I: begin
                RegWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                // IR holds the opcode, so LW/SW can be re-examined here
                w_next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) w_next_state = S_WB_MEM;
            end
            S_WB_MEM: begin
                MemtoReg     = 1'b1;
                RegWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = ALUOP_SUB;
                PCWriteCond  = 1'b1;
                PCSource     = PCSRC_ALUOUT;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                PCWrite      = 1'b1;
                PCSource     = PCSRC_JUMP;
                w_next_state = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: w_next_state = S_INIT;
        endcase

        // An instruction retires when control returns to FETCH from its last step
        w_retire = (w_next_state == S_FETCH) && (r_state != S_INIT) && (r_state != S_FETCH);
    end

    assign illegal_op  = r_illegal_op;
    assign instr_count = r_instr_count;

endmodule
